// File: rtl/teras_io_pkg.sv
// Shared definitions for the teras output path: word width, serializer
// states and the beats-per-word helper.
package teras_io_pkg;

  localparam int DATA_W = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  function automatic int beats(input int io_w);
    return DATA_W / io_w;
  endfunction

endpackage

// File: rtl/teras_sync_fifo.sv
// Single-clock FIFO with a first-word-fall-through head. Pointers carry one
// extra wrap bit so full and empty are distinguishable.
module teras_sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: empty/full gate every read of stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/teras_out_serializer.sv
// Buffers 32-bit result words and streams them LSB-first onto an IO_W-bit
// pad bus with rts/rtr handshake, start-of-word marker and pad enables.
// Handshake: a transfer happens on a clk edge where the sender's rts and the
// receiver's rtr are both high; the sender holds data stable until then.
module teras_out_serializer
  import teras_io_pkg::*;
#(
  parameter int IO_W  = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rts_i,
  output logic              rtr_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic              io_rtr_i,
  output logic              io_rts_o,
  output logic [IO_W-1:0]   io_data_o,
  output logic              io_sow_o,
  output logic [IO_W+1:0]   io_oeb_o,
  output logic [CNT_W-1:0]  words_sent_o
);

  localparam int BEATS = beats(IO_W);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  ser_state_e        state;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     beat;
  logic [DATA_W-1:0] head;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              take;
  logic              last_beat;

  assign rtr_o     = rst_n && !full;
  assign push      = rts_i && rtr_o;
  assign take      = (state == SHIFT) && io_rtr_i;
  assign last_beat = (beat == BW'(BEATS - 1));
  // Reload straight from the head on the last beat so words run without a bubble.
  assign pop       = !empty && ((state == IDLE) || (take && last_beat));

  teras_sync_fifo #(
    .W     (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (data_i),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      shreg        <= '0;
      beat         <= '0;
      words_sent_o <= '0;
      io_oeb_o     <= '1;
    end else begin
      io_oeb_o <= '0;
      case (state)
        IDLE: begin
          if (!empty) begin
            shreg <= head;
            beat  <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (take) begin
            if (last_beat) begin
              words_sent_o <= words_sent_o + 1'b1;
              beat         <= '0;
              if (!empty) begin
                shreg <= head;
              end else begin
                shreg <= shreg >> IO_W;
                state <= IDLE;
              end
            end else begin
              shreg <= shreg >> IO_W;
              beat  <= beat + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io_rts_o  = (state == SHIFT);
  assign io_data_o = shreg[IO_W-1:0];
  assign io_sow_o  = (state == SHIFT) && (beat == '0);

endmodule

// File: tb/tb_teras_out_serializer.sv
// Directed bench for teras_out_serializer: a default IO_W=8 instance plus a
// narrow-counter IO_W=32 instance for the wrap case.
module tb_teras_out_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // Default instance (IO_W=8, DEPTH=4, CNT_W=16)
  logic        rts_i = 1'b0;
  logic        rtr_o;
  logic [31:0] data_i = '0;
  logic        io_rtr_i = 1'b0;
  logic        io_rts_o;
  logic [7:0]  io_data_o;
  logic        io_sow_o;
  logic [9:0]  io_oeb_o;
  logic [15:0] words_sent_o;

  // Wrap instance (IO_W=32, DEPTH=2, CNT_W=4)
  logic        w_rts = 1'b0;
  logic        w_rtr;
  logic [31:0] w_data = '0;
  logic        w_io_rtr = 1'b0;
  logic        w_io_rts;
  logic [31:0] w_io_data;
  logic        w_io_sow;
  logic [33:0] w_io_oeb;
  logic [3:0]  w_words;

  int errors = 0;
  int checks = 0;
  int words_model = 0;
  logic [3:0] w_cnt_model = '0;

  logic [8:0]  exp_q[$];
  logic [31:0] exp2_q[$];

  teras_out_serializer #(.IO_W(8), .DEPTH(4), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rts_i        (rts_i),
    .rtr_o        (rtr_o),
    .data_i       (data_i),
    .io_rtr_i     (io_rtr_i),
    .io_rts_o     (io_rts_o),
    .io_data_o    (io_data_o),
    .io_sow_o     (io_sow_o),
    .io_oeb_o     (io_oeb_o),
    .words_sent_o (words_sent_o)
  );

  teras_out_serializer #(.IO_W(32), .DEPTH(2), .CNT_W(4)) dut_wrap (
    .clk          (clk),
    .rst_n        (rst_n),
    .rts_i        (w_rts),
    .rtr_o        (w_rtr),
    .data_i       (w_data),
    .io_rtr_i     (w_io_rtr),
    .io_rts_o     (w_io_rts),
    .io_data_o    (w_io_data),
    .io_sow_o     (w_io_sow),
    .io_oeb_o     (w_io_oeb),
    .words_sent_o (w_words)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Driver: present a word, wait for acceptance, record the expected beats
  task automatic push_word(input logic [31:0] w);
    int n = 0;
    rts_i  = 1'b1;
    data_i = w;
    while (!rtr_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("push_timeout", (n < 100), 1);
    for (int b = 0; b < 4; b++) exp_q.push_back({(b == 0), w[8*b +: 8]});
    words_model++;
    @(negedge clk);
    rts_i = 1'b0;
  endtask

  task automatic wait_rts();
    int n = 0;
    while (!io_rts_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rts_timeout", (n < 100), 1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", (n < 300), 1);
    @(negedge clk);
  endtask

  // Scoreboard monitors: a beat is consumed when rts and rtr are both high
  always @(negedge clk) begin
    #1;
    if (rst_n && io_rts_o && io_rtr_i) begin
      if (exp_q.size() == 0) begin
        chk("beat_unexpected", 1, 0);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        chk("beat_data", io_data_o, e[7:0]);
        chk("beat_sow", io_sow_o, e[8]);
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (rst_n && w_io_rts && w_io_rtr) begin
      if (exp2_q.size() == 0) begin
        chk("wrap_unexpected", 1, 0);
      end else begin
        chk("wrap_data", w_io_data, exp2_q.pop_front());
        chk("wrap_sow", w_io_sow, 1);
        chk("wrap_cnt", w_words, w_cnt_model);
        w_cnt_model = w_cnt_model + 4'd1;
      end
    end
  end

  initial begin
    int cnt;
    logic [7:0] stall_exp [6];
    logic       stall_rtr [6];

    // Reset state
    #12;
    chk("rst_rtr", rtr_o, 0);
    chk("rst_rts", io_rts_o, 0);
    chk("rst_data", io_data_o, 0);
    chk("rst_sow", io_sow_o, 0);
    chk("rst_oeb", io_oeb_o, 10'h3FF);
    chk("rst_words", words_sent_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("oeb_on", io_oeb_o, 0);
    chk("rtr_after_rst", rtr_o, 1);

    // Single word with latency
    io_rtr_i = 1'b1;
    push_word(32'hA1B2C3D4);
    chk("lat_edge_n1", io_rts_o, 0);
    @(negedge clk);
    chk("lat_edge_n2", io_rts_o, 1);
    cnt = 0;
    while (io_rts_o && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    chk("single_len", cnt, 4);
    chk("single_words", words_sent_o, words_model);
    chk("single_idle_data", io_data_o, 0);

    // Back-to-back words, no gap
    push_word(32'h00000001);
    push_word(32'hFFFFFFFF);
    wait_rts();
    cnt = 0;
    while (io_rts_o && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    chk("b2b_len", cnt, 8);
    chk("b2b_words", words_sent_o, words_model);

    // Backpressure until full
    io_rtr_i = 1'b0;
    for (int i = 0; i < 5; i++) push_word(32'h10203040 + i);
    chk("full_rtr", rtr_o, 0);
    chk("full_rts", io_rts_o, 1);
    chk("full_head", io_data_o, 8'h40);
    repeat (3) @(negedge clk);
    chk("full_rtr_hold", rtr_o, 0);
    chk("full_data_hold", io_data_o, 8'h40);
    io_rtr_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("full_rtr_before_pop", rtr_o, 0);
    end
    @(negedge clk);
    chk("rtr_after_pop", rtr_o, 1);
    drain();
    chk("full_words", words_sent_o, words_model);

    // Stall mid-word
    stall_exp = '{8'h44, 8'h33, 8'h33, 8'h33, 8'h22, 8'h11};
    stall_rtr = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    io_rtr_i = 1'b0;
    push_word(32'h11223344);
    wait_rts();
    for (int i = 0; i < 6; i++) begin
      chk("stall_beat", io_data_o, stall_exp[i]);
      io_rtr_i = stall_rtr[i];
      @(negedge clk);
    end
    chk("stall_done", io_rts_o, 0);
    chk("stall_words", words_sent_o, words_model);

    // Reset mid-operation with two words buffered
    io_rtr_i = 1'b0;
    push_word(32'hDEADBEEF);
    push_word(32'h01234567);
    push_word(32'h89ABCDEF);
    wait_rts();
    io_rtr_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_beat2", io_data_o, 8'hAD);
    io_rtr_i = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    words_model = 0;
    #1;
    chk("mid_rst_rts", io_rts_o, 0);
    chk("mid_rst_data", io_data_o, 0);
    chk("mid_rst_sow", io_sow_o, 0);
    chk("mid_rst_oeb", io_oeb_o, 10'h3FF);
    chk("mid_rst_rtr", rtr_o, 0);
    chk("mid_rst_words", words_sent_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    io_rtr_i = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (io_rts_o) cnt++;
    end
    chk("post_rst_activity", cnt, 0);
    chk("post_rst_words", words_sent_o, 0);
    chk("post_rst_rtr", rtr_o, 1);
    chk("post_rst_oeb", io_oeb_o, 0);

    // Counter wrap on the CNT_W=4, IO_W=32 instance
    w_io_rtr = 1'b1;
    for (int i = 0; i < 18; i++) begin
      int n = 0;
      w_rts  = 1'b1;
      w_data = 32'hC0DE0000 + i;
      while (!w_rtr && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("wrap_push_timeout", (n < 100), 1);
      exp2_q.push_back(w_data);
      @(negedge clk);
    end
    w_rts = 1'b0;
    cnt = 0;
    while (exp2_q.size() != 0 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("wrap_drain_timeout", (cnt < 100), 1);
    @(negedge clk);
    chk("wrap_final_words", w_words, 4'd2);

    chk("main_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/teras_out_serializer.md
Name: teras_out_serializer

Overview:
- Downstream stage of the teras core output.
- Accepts 32-bit matrix C result words on the core's master-side rts/rtr handshake and buffers them in a small FIFO.
- Serializes each word LSB-first onto a narrow IO_W-bit pad bus with its own rts/rtr handshake and a start-of-word marker.
- Provides pad output-enables and a sent-word counter for bring-up.

Parameters:
- IO_W, 8, pad data width in bits; must divide 32 (legal: 1, 2, 4, 8, 16, 32); BEATS = 32/IO_W.
- DEPTH, 4, FIFO depth in words; power of 2, >= 2.
- CNT_W, 16, width of words_sent_o.

Ports:
- clk  in  1  system clock, sole clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- rts_i  in  1  core has a valid result word (ready-to-send).
- rtr_o  out  1  block can accept a word (ready-to-receive).
- data_i  in  32  result word from core.
- io_rtr_i  in  1  pad-side consumer accepts the current beat.
- io_rts_o  out  1  a beat is valid on io_data_o.
- io_data_o  out  IO_W  current beat.
- io_sow_o  out  1  high on the first beat of each word.
- io_oeb_o  out  IO_W+2  active-low pad output enables covering data, rts and sow.
- words_sent_o  out  CNT_W  count of fully transmitted words.

Behaviour:
- Reset values (async assert, sync deassert of internal state):
  - FIFO empty; state IDLE; shift register 0; beat counter 0.
  - rtr_o 0 while rst_n is low, then !full; io_rts_o 0; io_data_o 0; io_sow_o 0.
  - io_oeb_o all 1; words_sent_o 0.
- Pad enables: io_oeb_o is registered and goes all 0 on the first clk edge after rst_n is released.
- Input side:
  - rtr_o = !fifo_full. A push occurs on an edge where rts_i && rtr_o.
  - data_i is ignored when rts_i is low.
  - No push is possible when full; the core must hold rts_i and data_i stable until accepted.
- FSM, state IDLE:
  - io_rts_o = 0.
  - If the FIFO is non-empty: pop the head into the shift register, set beat to 0, go to SHIFT.
- FSM, state SHIFT:
  - io_rts_o = 1; io_data_o = shreg[IO_W-1:0]; io_sow_o = (beat == 0).
  - On io_rtr_i: shift right by IO_W and increment beat.
  - On the last beat (beat == BEATS-1) with io_rtr_i:
    - increment words_sent_o;
    - if the FIFO is non-empty, pop the next word, set beat to 0 and stay in SHIFT (back-to-back, no bubble);
    - otherwise go to IDLE.
  - If io_rtr_i is low, all io_* outputs hold their values.
- Latency: a word accepted at edge N is loaded at edge N+1, and io_rts_o is high during the cycle after edge N+1. Minimum occupancy is BEATS cycles per word.
- Simultaneous push and pop: both occur in the same cycle; occupancy is unchanged. A pop from a full FIFO re-enables rtr_o the cycle after the pop.
- FIFO pointers: log2(DEPTH)+1 bits so that full and empty are distinguishable; wrap is modulo 2*DEPTH.
- words_sent_o wraps from 2^CNT_W-1 to 0 without saturating.
- Reset mid-word: any in-flight and buffered words are discarded; no partial word is resent.
- IO_W == 32: BEATS = 1, and io_sow_o is high on every beat.

Decomposition:
- Package teras_io_pkg:
  - DATA_W = 32;
  - the serializer state enum {IDLE, SHIFT};
  - a function beats(io_w) returning 32/io_w.
- Sub-module teras_sync_fifo:
  - parameters W, DEPTH;
  - ports push, pop, din, dout, full, empty;
  - first-word-fall-through head;
  - same clk/rst_n.
- The serializer FSM, shift register and counter stay in the top module.

Test Plan:
- Single word: reset, push 0xA1B2C3D4 with io_rtr_i = 1 -> io_rts_o high from cycle N+2 for 4 cycles. Beats are 0xD4, 0xC3, 0xB2, 0xA1; io_sow_o high on 0xD4 only; words_sent_o = 1; return to IDLE.
- Back-to-back: push 0x00000001 and 0xFFFFFFFF on consecutive cycles -> 8 contiguous beats 01,00,00,00,FF,FF,FF,FF with no io_rts_o gap; io_sow_o high on beats 0 and 4.
- Backpressure/full: hold io_rtr_i = 0 and push 5 words with DEPTH = 4 -> 1 word is in the shift register and 4 in the FIFO; rtr_o drops after the 5th accept and stays low while io_data_o is stable. Release io_rtr_i -> all 5 words come out in order; rtr_o rises the cycle after the first pop.
- Stall mid-word: toggle io_rtr_i 1,0,0,1,1,1 on 0x11223344 -> the beat holds at 0x33 during the stall; beat sequence is 44,33,33,33,22,11 as observed per cycle.
- Reset mid-operation: assert rst_n low during beat 2 with 2 words buffered -> outputs immediately take their reset values and io_oeb_o is all 1. After release: no output activity, words_sent_o = 0, rtr_o = 1.
- Counter wrap: force 65536 transfers (or a CNT_W = 4 build with 16 words) -> words_sent_o wraps to 0.
